// File: rtl/counter_pkg.sv
// Purpose : shared defaults and constant helpers for the parameterised counter.
// Latency : n/a (package only).
// Backpressure: n/a.
package counter_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int SATURATE_DEF = 0;
    localparam int PRESCALE_DEF = 1;

    // Ceiling log2: smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Prescaler phase register width; at least one bit so the vector is legal.
    function automatic int phase_width(input int prescale);
        return (prescale <= 1) ? 1 : clog2(prescale);
    endfunction

    // Default highest count for a given width: all ones.
    function automatic longint unsigned max_count_def(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Purpose : divides qualified enable cycles by PRESCALE, emitting a one-cycle step.
// Latency : step is combinational on enable and the registered phase.
// Backpressure: enable low freezes the phase; clear returns it to zero.
//
// Ports: clk, reset (sync, active-high), enable (cycle qualifier),
//        clear (phase restart), step (count-step strobe).
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Every enabled cycle is a step; no state needed.
            logic unused_ok;
            assign unused_ok = ^{clk, reset, clear};
            assign step      = enable;
        end else begin : g_div
            localparam int            PW   = phase_width(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;

            always_comb begin
                phase_d = phase_q;
                if (clear) begin
                    phase_d = '0;
                end else if (enable) begin
                    phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            // The PRESCALE-th enabled cycle is the one that sees the last phase.
            assign step = enable && !clear && (phase_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_param.sv
// Purpose : up/down counter with load, wrap/saturate at limits, prescaler, sticky overflow.
// Latency : out/wrap/ovf registered (1 edge); tc combinational on out and up.
// Backpressure: enable low holds count and prescaler phase; no handshake.
//
// Ports: clk, reset (sync, active-high), set/in (load, clamped to MAX_COUNT),
//        enable/up (count control), clr_ovf (clears sticky flag),
//        out (count), tc (terminal count), wrap (limit-event pulse), ovf (sticky).
module counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH     = WIDTH_DEF,
    parameter longint unsigned MAX_COUNT = max_count_def(WIDTH),
    parameter int              SATURATE  = SATURATE_DEF,
    parameter int              PRESCALE  = PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    input  logic             up,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step;
    logic             limit_evt;

    // A load takes the edge, so it neither advances nor restarts-after the
    // phase: it just restarts it.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable && !set),
        .clear  (set),
        .step   (step)
    );

    assign tc = up ? (out_q == MAX_VAL) : (out_q == '0);

    always_comb begin
        out_d     = out_q;
        limit_evt = 1'b0;
        if (set) begin
            out_d = (in > MAX_VAL) ? MAX_VAL : in;
        end else if (step) begin
            if (tc) begin
                // Stepping past a limit: wrap to the opposite end or hold.
                limit_evt = 1'b1;
                if (SATURATE == 0) begin
                    out_d = up ? '0 : MAX_VAL;
                end
            end else begin
                out_d = up ? out_q + 1'b1 : out_q - 1'b1;
            end
        end

        wrap_d = limit_evt;

        // A limit event on the same edge as a clear request keeps the flag set.
        ovf_d = ovf_q;
        if (limit_evt) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_counter_param.sv
module tb_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       set;
    logic [3:0] in;
    logic       enable;
    logic       up;
    logic       clr_ovf;

    logic [3:0] out_def, out_sat, out_m9, out_ps;
    logic       tc_def, tc_sat, tc_m9, tc_ps;
    logic       wrap_def, wrap_sat, wrap_m9, wrap_ps;
    logic       ovf_def, ovf_sat, ovf_m9, ovf_ps;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_param #(.WIDTH(4)) u_def (
        .clk(clk), .reset(reset), .set(set), .in(in), .enable(enable), .up(up),
        .clr_ovf(clr_ovf), .out(out_def), .tc(tc_def), .wrap(wrap_def), .ovf(ovf_def)
    );

    counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .set(set), .in(in), .enable(enable), .up(up),
        .clr_ovf(clr_ovf), .out(out_sat), .tc(tc_sat), .wrap(wrap_sat), .ovf(ovf_sat)
    );

    counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_m9 (
        .clk(clk), .reset(reset), .set(set), .in(in), .enable(enable), .up(up),
        .clr_ovf(clr_ovf), .out(out_m9), .tc(tc_m9), .wrap(wrap_m9), .ovf(ovf_m9)
    );

    counter_param #(.WIDTH(4), .PRESCALE(3)) u_ps (
        .clk(clk), .reset(reset), .set(set), .in(in), .enable(enable), .up(up),
        .clr_ovf(clr_ovf), .out(out_ps), .tc(tc_ps), .wrap(wrap_ps), .ovf(ovf_ps)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        set     = 1'b0;
        in      = 4'd0;
        enable  = 1'b0;
        clr_ovf = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; set = 1'b0; in = 4'd0; enable = 1'b0; up = 1'b1; clr_ovf = 1'b0;

        // Reset state and tc direction dependence.
        do_reset();
        check("rst_out", out_def, 0);
        check("rst_wrap", wrap_def, 0);
        check("rst_ovf", ovf_def, 0);
        up = 1'b0; #1;
        check("rst_tc_down", tc_def, 1);
        up = 1'b1; #1;
        check("rst_tc_up", tc_def, 0);

        // Default counter wraps 15 -> 0 on the 16th edge.
        enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check($sformatf("def_out_%0d", i), out_def, i % 16);
            check($sformatf("def_wrap_%0d", i), wrap_def, (i == 16) ? 1 : 0);
            if (i == 15) begin
                check("def_tc_at15", tc_def, 1);
                check("def_ovf_pre", ovf_def, 0);
            end
        end
        check("def_ovf_post", ovf_def, 1);

        // Saturating MAX_COUNT=9: clamped load, held limits, two wrap pulses.
        do_reset();
        up = 1'b1; set = 1'b1; in = 4'd12;
        tick();
        set = 1'b0;
        check("sat_load_clamp", out_sat, 9);
        check("sat_load_nowrap", wrap_sat, 0);
        check("sat_tc", tc_sat, 1);
        enable = 1'b1;
        tick();
        check("sat_hold_max", out_sat, 9);
        check("sat_wrap_up", wrap_sat, 1);
        check("sat_ovf", ovf_sat, 1);
        up = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("sat_dn_out_%0d", k), out_sat, (k <= 9) ? 9 - k : 0);
            check($sformatf("sat_dn_wrap_%0d", k), wrap_sat, (k == 10) ? 1 : 0);
        end

        // Wrapping MAX_COUNT=9 counting down from 0.
        do_reset();
        up = 1'b0; #1;
        check("m9_tc_zero", tc_m9, 1);
        enable = 1'b1;
        tick();
        check("m9_wrap_out", out_m9, 9);
        check("m9_wrap_pulse", wrap_m9, 1);
        enable = 1'b0;
        tick();
        check("m9_wrap_gone", wrap_m9, 0);
        check("m9_tc_after", tc_m9, 0);
        check("m9_hold", out_m9, 9);

        // PRESCALE=3: steps on edges 3, 6, 9; a two-cycle stall at phase 2.
        do_reset();
        up = 1'b1; enable = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            check($sformatf("ps_out_e%0d", e), out_ps, e / 3);
        end
        enable = 1'b0;
        tick();
        check("ps_stall1", out_ps, 3);
        tick();
        check("ps_stall2", out_ps, 3);
        enable = 1'b1;
        tick();
        check("ps_resume", out_ps, 4);

        // Direction flip mid-prescale keeps phase; direction taken at the step.
        tick();
        check("ps_dir_p1", out_ps, 4);
        up = 1'b0;
        tick();
        check("ps_dir_p2", out_ps, 4);
        tick();
        check("ps_dir_step", out_ps, 3);

        // Reset mid-prescale clears phase.
        up = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ps_rst_out", out_ps, 0);
        tick();
        tick();
        check("ps_rst_phase", out_ps, 0);
        tick();
        check("ps_rst_step", out_ps, 1);

        // Load restarts the phase.
        tick();
        set = 1'b1; in = 4'd7;
        tick();
        set = 1'b0;
        check("ps_set_out", out_ps, 7);
        tick();
        tick();
        check("ps_set_phase", out_ps, 7);
        tick();
        check("ps_set_step", out_ps, 8);

        // Reset beats set; then set beats a count step.
        reset = 1'b1; set = 1'b1; in = 4'd5; enable = 1'b1; up = 1'b1;
        tick();
        check("prio_rst_out", out_def, 0);
        reset = 1'b0;
        tick();
        check("prio_set_out", out_def, 5);
        check("prio_set_wrap", wrap_def, 0);
        check("prio_set_ovf", ovf_def, 0);

        // Sticky overflow: a limit event beats clr_ovf on the same edge.
        in = 4'd15;
        tick();
        set = 1'b0;
        check("ovf_load", out_def, 15);
        tick();
        check("ovf_first_wrap", wrap_def, 1);
        check("ovf_first_set", ovf_def, 1);
        set = 1'b1;
        tick();
        set = 1'b0;
        check("ovf_reload", out_def, 15);
        check("ovf_set_keeps", ovf_def, 1);
        check("ovf_set_nowrap", wrap_def, 0);
        clr_ovf = 1'b1;
        tick();
        check("ovf_race_out", out_def, 0);
        check("ovf_race_wrap", wrap_def, 1);
        check("ovf_race_keep", ovf_def, 1);
        enable = 1'b0;
        tick();
        check("ovf_cleared", ovf_def, 0);
        check("ovf_clr_nowrap", wrap_def, 0);
        clr_ovf = 1'b0;
        tick();
        check("ovf_stays_clear", ovf_def, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_param.md
COUNTER_PARAM -- requirements
Module: counter_param

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits (2..32).
- REQ-002 The block SHALL have parameter MAX_COUNT, default 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1.
- REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
- REQ-004 The block SHALL have parameter PRESCALE, default 1: enabled cycles per count step (1..256).
- REQ-005 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
- REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-007 The block SHALL have port set, input, 1: synchronous load of in into out.
- REQ-008 The block SHALL have port in, input, WIDTH: load value.
- REQ-009 The block SHALL have port enable, input, 1: count qualifier.
- REQ-010 The block SHALL have port up, input, 1: 1 = count up, 0 = count down.
- REQ-011 The block SHALL have port clr_ovf, input, 1: clears the sticky overflow flag.
- REQ-012 The block SHALL have port out, output, WIDTH: registered count.
- REQ-013 The block SHALL have port tc, output, 1: combinational terminal count.
- REQ-014 The block SHALL have port wrap, output, 1: registered one-cycle pulse on a limit event.
- REQ-015 The block SHALL have port ovf, output, 1: sticky limit-event flag.

Function
- REQ-016 Priority per edge SHALL be reset > set > count step; lower-priority actions are ignored that cycle.
- REQ-017 On set, out SHALL take in on the next edge; in > MAX_COUNT SHALL load MAX_COUNT.
- REQ-018 Set SHALL also clear the prescaler phase and SHALL NOT assert wrap or modify ovf.
- REQ-019 The prescaler SHALL count cycles with enable=1 and set=0 and issue a step on every PRESCALE-th such cycle; PRESCALE=1 steps on every enabled cycle.
- REQ-020 With enable=0, out and prescaler phase SHALL hold.
- REQ-021 On a step with up=1 and out<MAX_COUNT, out SHALL increment by 1; with up=0 and out>0, out SHALL decrement by 1.
- REQ-022 On a step with up=1 and out==MAX_COUNT, out SHALL become 0 (SATURATE=0) or hold MAX_COUNT (SATURATE=1).
- REQ-023 On a step with up=0 and out==0, out SHALL become MAX_COUNT (SATURATE=0) or hold 0 (SATURATE=1).
- REQ-024 Each REQ-022/023 step is a limit event: wrap SHALL be 1 for exactly the cycle after the event edge, and ovf SHALL set on that edge.
- REQ-025 tc SHALL be 1 when (up=1 and out==MAX_COUNT) or (up=0 and out==0), independent of enable.
- REQ-026 clr_ovf SHALL clear ovf on the next edge; a limit event on the same edge SHALL win (ovf=1).
- REQ-027 Changing up mid-prescale SHALL not reset the prescaler phase; direction is sampled at the step edge.
- REQ-028 out SHALL never exceed MAX_COUNT after any edge.

Reset
- REQ-029 On reset edge: out=0, wrap=0, ovf=0, prescaler phase=0; tc then reflects REQ-025 (tc=1 if up=0).
- REQ-030 Reset asserted mid-prescale or during set SHALL take effect fully on that edge.

Structure
- REQ-031 Shared package counter_pkg SHALL hold the parameter defaults and a clog2 helper constant function for prescaler width.
- REQ-032 The prescaler SHALL be sub-module counter_prescaler (inputs clk, reset, enable, clear; output step); PRESCALE=1 SHALL reduce to step=enable.

Verification
- REQ-033 WIDTH=4, defaults: reset, enable=1, up=1, 17 edges -> out 1..15,0,1; wrap pulse after 16th edge; ovf=1.
- REQ-034 SATURATE=1, MAX_COUNT=9: set in=12 -> out=9; up step -> out stays 9, wrap pulse, ovf=1; up=0 10 steps -> 8..0 then hold 0, second wrap.
- REQ-035 MAX_COUNT=9, up=0 from out=0 -> out=9, wrap=1 one cycle, tc=0 after.
- REQ-036 PRESCALE=3, enable=1, up=1 from 0 -> out increments on edges 3,6,9; enable low 2 cycles at phase 2 -> next step delayed 2 cycles.
- REQ-037 Same edge: reset=1, set=1, in=5 -> out=0; next edge set=1, enable=1 -> out=5, no step.
- REQ-038 ovf=1, clr_ovf=1 on same edge as a wrap -> ovf stays 1; next edge clr_ovf=1 alone -> ovf=0.
